serial_inst_loader: RTL and testbench

//  Parametrised serial-to-parallel program loader for the instruction memory.

---
 rtl/serial_inst_loader_if.sv | 28 ++
 rtl/serial_inst_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_serial_inst_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_inst_loader_if.sv
// Upload-link and instruction-memory write-port bundle for serial_inst_loader.
// The slave modport is the loader's view; master is the host/memory side.
interface serial_inst_loader_if #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 10
);
   logic              upload;
   logic              bit_in;
   logic              bit_rdy;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [ADDR_W:0]   word_count;
   logic              busy;
   logic              done;
   logic              overflow;
   logic              parity_err;

   modport slave (
      input  upload, bit_in, bit_rdy,
      output mem_we, mem_addr, mem_wdata, word_count, busy, done, overflow, parity_err
   );

   modport master (
      output upload, bit_in, bit_rdy,
      input  mem_we, mem_addr, mem_wdata, word_count, busy, done, overflow, parity_err
   );
endinterface

// File: rtl/serial_inst_loader.sv
// Serial-to-parallel program loader for the instruction memory.
// Assembles WORD_W-bit words from a synchronised bit_in/bit_rdy link and writes
// them to consecutive addresses starting at 0 while upload is high.
// Optional feature macro: LOADER_PARITY_EN (even parity bit after every word).
module serial_inst_loader #(
   parameter int WORD_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int MSB_FIRST = 0,
   parameter int SYNC_STG  = 2
) (
   input logic                 clk,
   input logic                 reset,
   serial_inst_loader_if.slave lif
);
   localparam int              CNT_W    = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
   localparam logic [ADDR_W:0]  LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

`ifdef LOADER_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_SHIFT = 3'd1, ST_WRITE = 3'd2,
                             ST_FULL = 3'd3, ST_PAR = 3'd4} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_WRITE = 2'd2,
                             ST_FULL = 2'd3} state_t;
`endif

   // Insert one received bit at the end of the word selected by MSB_FIRST.
   function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] w, input logic b);
      if (MSB_FIRST != 0) begin
         return {w[WORD_W-2:0], b};
      end else begin
         return {b, w[WORD_W-1:1]};
      end
   endfunction

   // Even-parity bit over a word (the bit that makes the total count of ones even).
   function automatic logic even_par(input logic [WORD_W-1:0] w);
      return ^w;
   endfunction

   state_t              state_r, state_nxt_s;
   logic [SYNC_STG-1:0] rdy_sync_r, bit_sync_r;
   logic                rdy_prev_r, strobe_r, bit_r, upload_prev_r;
   logic [WORD_W-1:0]   shreg_r, shreg_nxt_s, word_s;
   logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_nxt_s;
   logic [ADDR_W:0]     wcnt_r, wcnt_nxt_s;
   logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
   logic [WORD_W-1:0]   wdata_r, wdata_nxt_s;
   logic                we_r, we_nxt_s, done_r, done_nxt_s, busy_r, busy_nxt_s;
   logic                ovf_r, ovf_nxt_s, perr_r, perr_nxt_s;

   // Synchronise the asynchronous link and turn bit_rdy rising edges into one-clk strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_sync_r    <= '0;
         bit_sync_r    <= '0;
         rdy_prev_r    <= 1'b0;
         strobe_r      <= 1'b0;
         bit_r         <= 1'b0;
         upload_prev_r <= 1'b0;
      end else begin
         rdy_sync_r    <= {rdy_sync_r[SYNC_STG-2:0], lif.bit_rdy};
         bit_sync_r    <= {bit_sync_r[SYNC_STG-2:0], lif.bit_in};
         rdy_prev_r    <= rdy_sync_r[SYNC_STG-1];
         strobe_r      <= rdy_sync_r[SYNC_STG-1] & ~rdy_prev_r;
         bit_r         <= bit_sync_r[SYNC_STG-1];
         upload_prev_r <= lif.upload;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and next-value logic for the FSM, datapath and registered outputs.
   always_comb begin
      state_nxt_s   = state_r;
      shreg_nxt_s   = shreg_r;
      bit_cnt_nxt_s = bit_cnt_r;
      wcnt_nxt_s    = wcnt_r;
      addr_nxt_s    = addr_r;
      wdata_nxt_s   = wdata_r;
      ovf_nxt_s     = ovf_r;
      perr_nxt_s    = perr_r;
      we_nxt_s      = 1'b0;
      done_nxt_s    = 1'b0;
      word_s        = shift_in(shreg_r, bit_r);
      case (state_r)
         ST_IDLE: begin
            if (lif.upload && !upload_prev_r) begin
               state_nxt_s   = ST_SHIFT;
               shreg_nxt_s   = '0;
               bit_cnt_nxt_s = '0;
               wcnt_nxt_s    = '0;
               ovf_nxt_s     = 1'b0;
               perr_nxt_s    = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (!lif.upload) begin
               state_nxt_s = ST_IDLE;
               done_nxt_s  = 1'b1;
            end else if (strobe_r) begin
               shreg_nxt_s = word_s;
               if (bit_cnt_r == LAST_BIT) begin
                  bit_cnt_nxt_s = '0;
`ifdef LOADER_PARITY_EN
                  state_nxt_s   = ST_PAR;
`else
                  state_nxt_s   = ST_WRITE;
                  we_nxt_s      = 1'b1;
                  wdata_nxt_s   = word_s;
                  addr_nxt_s    = wcnt_r[ADDR_W-1:0];
`endif
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
               end
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
`ifdef LOADER_PARITY_EN
         ST_PAR: begin
            if (!lif.upload) begin
               state_nxt_s = ST_IDLE;
               done_nxt_s  = 1'b1;
            end else if (strobe_r) begin
               if ((even_par(shreg_r) ^ bit_r) == 1'b0) begin
                  state_nxt_s = ST_WRITE;
                  we_nxt_s    = 1'b1;
                  wdata_nxt_s = shreg_r;
                  addr_nxt_s  = wcnt_r[ADDR_W-1:0];
               end else begin
                  state_nxt_s = ST_SHIFT;
                  perr_nxt_s  = 1'b1;
               end
            end else begin
               state_nxt_s = ST_PAR;
            end
         end
`endif
         ST_WRITE: begin
            // The write itself happens this cycle; a strobe here opens the next word.
            wcnt_nxt_s = wcnt_r + (ADDR_W + 1)'(1);
            if (!lif.upload) begin
               state_nxt_s = ST_IDLE;
               done_nxt_s  = 1'b1;
            end else if (wcnt_r == LAST_CNT) begin
               state_nxt_s = ST_FULL;
               ovf_nxt_s   = ovf_r | strobe_r;
            end else begin
               state_nxt_s = ST_SHIFT;
               if (strobe_r) begin
                  shreg_nxt_s   = word_s;
                  bit_cnt_nxt_s = CNT_W'(1);
               end else begin
                  bit_cnt_nxt_s = '0;
               end
            end
         end
         ST_FULL: begin
            if (!lif.upload) begin
               state_nxt_s = ST_IDLE;
               done_nxt_s  = 1'b1;
            end else if (strobe_r) begin
               ovf_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      busy_nxt_s = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FULL);
   end

   // Datapath and registered-output update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_r   <= '0;
         bit_cnt_r <= '0;
         wcnt_r    <= '0;
         addr_r    <= '0;
         wdata_r   <= '0;
         we_r      <= 1'b0;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
         ovf_r     <= 1'b0;
         perr_r    <= 1'b0;
      end else begin
         shreg_r   <= shreg_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         wcnt_r    <= wcnt_nxt_s;
         addr_r    <= addr_nxt_s;
         wdata_r   <= wdata_nxt_s;
         we_r      <= we_nxt_s;
         done_r    <= done_nxt_s;
         busy_r    <= busy_nxt_s;
         ovf_r     <= ovf_nxt_s;
         perr_r    <= perr_nxt_s;
      end
   end

   assign lif.mem_we     = we_r;
   assign lif.mem_addr   = addr_r;
   assign lif.mem_wdata  = wdata_r;
   assign lif.word_count = wcnt_r;
   assign lif.busy       = busy_r;
   assign lif.done       = done_r;
   assign lif.overflow   = ovf_r;
   assign lif.parity_err = perr_r;
endmodule

// File: tb/tb_serial_inst_loader.sv
// Directed self-checking bench for serial_inst_loader.
// dut_a: default geometry; dut_b: ADDR_W=2 for the full/overflow case;
// dut_c: MSB_FIRST=1, SYNC_STG=3. All three share the same link stimulus.
module tb_serial_inst_loader;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic upload = 1'b0;
   logic bit_in = 1'b0;
   logic bit_rdy = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_rise_cyc = 0;
   int   last_we_cyc = 0;
   int   done_cnt_a = 0;
   int   wr_cnt_b = 0;
   logic [1:0]  last_addr_b = 2'd0;
   logic [31:0] last_data_c = 32'd0;
   logic [9:0]  wa_q[$];
   logic [31:0] wd_q[$];
   int   n0, d0, b0;

   always #5 clk = ~clk;

   serial_inst_loader_if #(.WORD_W(32), .ADDR_W(10)) bus_a ();
   serial_inst_loader_if #(.WORD_W(32), .ADDR_W(2))  bus_b ();
   serial_inst_loader_if #(.WORD_W(32), .ADDR_W(10)) bus_c ();

   assign bus_a.upload = upload;  assign bus_a.bit_in = bit_in;  assign bus_a.bit_rdy = bit_rdy;
   assign bus_b.upload = upload;  assign bus_b.bit_in = bit_in;  assign bus_b.bit_rdy = bit_rdy;
   assign bus_c.upload = upload;  assign bus_c.bit_in = bit_in;  assign bus_c.bit_rdy = bit_rdy;

   serial_inst_loader #(.WORD_W(32), .ADDR_W(10), .MSB_FIRST(0), .SYNC_STG(2))
      dut_a (.clk(clk), .reset(reset), .lif(bus_a.slave));
   serial_inst_loader #(.WORD_W(32), .ADDR_W(2), .MSB_FIRST(0), .SYNC_STG(2))
      dut_b (.clk(clk), .reset(reset), .lif(bus_b.slave));
   serial_inst_loader #(.WORD_W(32), .ADDR_W(10), .MSB_FIRST(1), .SYNC_STG(3))
      dut_c (.clk(clk), .reset(reset), .lif(bus_c.slave));

   // Clock-edge counter used to measure write latency.
   always @(posedge clk) cyc <= cyc + 1;

   // Write/done monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus_a.mem_we === 1'b1) begin
         wa_q.push_back(bus_a.mem_addr);
         wd_q.push_back(bus_a.mem_wdata);
         last_we_cyc <= cyc;
      end
      if (bus_a.done === 1'b1) done_cnt_a <= done_cnt_a + 1;
      if (bus_b.mem_we === 1'b1) begin
         wr_cnt_b    <= wr_cnt_b + 1;
         last_addr_b <= bus_b.mem_addr;
      end
      if (bus_c.mem_we === 1'b1) last_data_c <= bus_c.mem_wdata;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // One link bit: rdy high 3 clks, low 3 clks (period 6 clks).
   task automatic send_bit(input logic b);
      @(negedge clk);
      bit_in = b;
      bit_rdy = 1'b1;
      last_rise_cyc = cyc;
      repeat (3) @(negedge clk);
      bit_rdy = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_word_from(input logic [31:0] w, input int first);
      for (int i = first; i < 32; i++) send_bit(w[i]);
`ifdef LOADER_PARITY_EN
      send_bit(^w);
`endif
   endtask

   task automatic send_word(input logic [31:0] w);
      send_word_from(w, 0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_we", bus_a.mem_we, 64'd0);
      check_val("rst_busy", bus_a.busy, 64'd0);
      check_val("rst_wcnt", bus_a.word_count, 64'd0);
      check_val("rst_addr_data", {bus_a.mem_addr, bus_a.mem_wdata}, 64'd0);
      check_val("rst_flags", {bus_a.done, bus_a.overflow, bus_a.parity_err}, 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: reset mid-session, then strobes with upload low are ignored
      upload = 1'b1;
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      check_val("t1_busy_before", bus_a.busy, 64'd1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_val("t1_busy", bus_a.busy, 64'd0);
      check_val("t1_outs", {bus_a.mem_we, bus_a.done, bus_a.word_count}, 64'd0);
      upload = 1'b0;
      reset = 1'b1;
      n0 = wa_q.size();
      for (int i = 0; i < 40; i++) send_bit(1'b1);
      check_val("t1_no_write", wa_q.size() - n0, 64'd0);
      check_val("t1_idle_busy", bus_a.busy, 64'd0);

      // 2: single word, LSB first
      n0 = wa_q.size();
      upload = 1'b1;
      @(negedge clk);
      send_word(32'h2008_0005);
      repeat (4) @(negedge clk);
      check_val("t2_nwr", wa_q.size() - n0, 64'd1);
      check_val("t2_addr", wa_q[n0], 64'd0);
      check_val("t2_data", wd_q[n0], 64'h2008_0005);
      check_val("t2_wcnt", bus_a.word_count, 64'd1);
      check_val("t2_busy", bus_a.busy, 64'd1);
      check_val("t2_latency", last_we_cyc - last_rise_cyc, 64'd4);
      check_val("t2_msb_first", last_data_c, 64'hA000_1004);
      d0 = done_cnt_a;
      upload = 1'b0;
      repeat (3) @(negedge clk);
      check_val("t2_done", done_cnt_a - d0, 64'd1);
      check_val("t2_wcnt_hold", bus_a.word_count, 64'd1);
      check_val("t2_idle_busy", bus_a.busy, 64'd0);

      // 3: three words then upload drop
      n0 = wa_q.size();
      d0 = done_cnt_a;
      upload = 1'b1;
      @(negedge clk);
      send_word(32'hDEAD_BEEF);
      send_word(32'h0123_4567);
      send_word(32'hA5A5_0F0F);
      upload = 1'b0;
      repeat (3) @(negedge clk);
      check_val("t3_nwr", wa_q.size() - n0, 64'd3);
      check_val("t3_addrs", {wa_q[n0], wa_q[n0+1], wa_q[n0+2]}, {34'd0, 10'd0, 10'd1, 10'd2});
      check_val("t3_data01", {wd_q[n0], wd_q[n0+1]}, 64'hDEAD_BEEF_0123_4567);
      check_val("t3_data2", wd_q[n0+2], 64'hA5A5_0F0F);
      check_val("t3_done", done_cnt_a - d0, 64'd1);
      check_val("t3_wcnt", bus_a.word_count, 64'd3);

      // 4: 40 bits, trailing 8 discarded
      n0 = wa_q.size();
      upload = 1'b1;
      @(negedge clk);
      send_word(32'hCAFE_F00D);
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      upload = 1'b0;
      repeat (3) @(negedge clk);
      check_val("t4_nwr", wa_q.size() - n0, 64'd1);
      check_val("t4_addr", wa_q[n0], 64'd0);
      check_val("t4_data", wd_q[n0], 64'hCAFE_F00D);
      check_val("t4_wcnt", bus_a.word_count, 64'd1);

      // 5: ADDR_W=2 fills after 4 words, 5th word overflows
      b0 = wr_cnt_b;
      upload = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) send_word(32'h1111_0000 + k);
      check_val("t5_nwr_b", wr_cnt_b - b0, 64'd4);
      check_val("t5_last_addr_b", last_addr_b, 64'd3);
      check_val("t5_wcnt_b", bus_b.word_count, 64'd4);
      check_val("t5_busy_b", bus_b.busy, 64'd0);
      check_val("t5_ovf_before", bus_b.overflow, 64'd0);
      send_bit(1'b0);
      check_val("t5_ovf_first_bit", bus_b.overflow, 64'd1);
      n0 = wa_q.size();
      send_word_from(32'h5555_AAAA, 1);
      repeat (2) @(negedge clk);
      check_val("t5_nwr_b_after", wr_cnt_b - b0, 64'd4);
      check_val("t5_a_5th", {wa_q[n0], wd_q[n0]}, {22'd0, 10'd4, 32'h5555_AAAA});
      check_val("t5_a_wcnt", bus_a.word_count, 64'd5);
      upload = 1'b0;
      repeat (3) @(negedge clk);
      check_val("t5_ovf_hold", bus_b.overflow, 64'd1);
      upload = 1'b1;
      repeat (2) @(negedge clk);
      check_val("t5_ovf_clear", bus_b.overflow, 64'd0);
      check_val("t5_new_session", {bus_b.busy, bus_b.word_count}, {61'd0, 1'b1, 3'd0});
      upload = 1'b0;
      repeat (3) @(negedge clk);

`ifdef LOADER_PARITY_EN
      // 6: bad parity drops the word, next good word lands at addr 0
      n0 = wa_q.size();
      upload = 1'b1;
      @(negedge clk);
      send_bit(1'b1);
      for (int i = 1; i < 32; i++) send_bit(1'b0);
      send_bit(1'b0);
      repeat (2) @(negedge clk);
      check_val("t6_perr", bus_a.parity_err, 64'd1);
      check_val("t6_no_write", wa_q.size() - n0, 64'd0);
      check_val("t6_wcnt0", bus_a.word_count, 64'd0);
      send_word(32'h0000_0003);
      repeat (2) @(negedge clk);
      check_val("t6_nwr", wa_q.size() - n0, 64'd1);
      check_val("t6_addr_data", {wa_q[n0], wd_q[n0]}, {22'd0, 10'd0, 32'h0000_0003});
      check_val("t6_perr_hold", bus_a.parity_err, 64'd1);
      upload = 1'b0;
      repeat (3) @(negedge clk);
`else
      check_val("no_par_perr", bus_a.parity_err, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
